// File: rtl/commit_ctrl_pkg.sv
// Shared retirement definitions: ROB index width, head entry
// type encodings and the commit sequencer state encoding.
package commit_ctrl_pkg;

   localparam int ROB_WIDTH = 4;

   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_STORE  = 2'd1;
   localparam logic [1:0] TYPE_BRANCH = 2'd2;
   localparam logic [1:0] TYPE_HALT   = 2'd3;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STORE_WAIT,
      ST_PRE_FLUSH,
      ST_FLUSH,
      ST_HALT
   } state_e;

endpackage

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: pops the ROB head, drives the
// register commit port, store release handshake and flush pulse.
module commit_ctrl
   import commit_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 head_valid,
   input  logic                 head_ready,
   input  logic [ROB_WIDTH-1:0] head_rob_id,
   input  logic [1:0]           head_type,
   input  logic [4:0]           head_rd,
   input  logic [31:0]          head_val,
   input  logic                 head_mispredict,
   input  logic [31:0]          head_target,
   output logic                 head_pop,
   output logic [4:0]           commit_reg_id,
   output logic [31:0]          commit_val,
   output logic [ROB_WIDTH-1:0] commit_rob_id,
   output logic                 store_req,
   output logic [ROB_WIDTH-1:0] store_rob_id,
   input  logic                 store_ack,
   output logic                 clear,
   output logic [31:0]          clear_pc,
   output logic                 halted,
   output logic [31:0]          retire_count
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [31:0]          target_q, target_d;
   logic [4:0]           commit_reg_id_q, commit_reg_id_d;
   logic [31:0]          commit_val_q, commit_val_d;
   logic [ROB_WIDTH-1:0] commit_rob_id_q, commit_rob_id_d;
   logic                 store_req_q, store_req_d;
   logic [ROB_WIDTH-1:0] store_rob_id_q, store_rob_id_d;
   logic                 clear_q, clear_d;
   logic [31:0]          clear_pc_q, clear_pc_d;
   logic                 halted_q, halted_d;
   logic [31:0]          retire_count_q, retire_count_d;
   logic                 pop;
   logic                 take;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      target_d        = target_q;
      commit_reg_id_d = '0;
      commit_val_d    = commit_val_q;
      commit_rob_id_d = commit_rob_id_q;
      store_req_d     = store_req_q;
      store_rob_id_d  = store_rob_id_q;
      clear_d         = 1'b0;
      clear_pc_d      = '0;
      halted_d        = halted_q;
      pop             = 1'b0;
      take            = head_valid && head_ready;

      unique case (state_q)
         ST_RUN: begin
            if (take) begin
               unique case (head_type)
                  TYPE_STORE: begin
                     store_req_d    = 1'b1;
                     store_rob_id_d = head_rob_id;
                     state_d        = ST_STORE_WAIT;
                  end
                  TYPE_HALT: begin
                     pop      = 1'b1;
                     halted_d = 1'b1;
                     state_d  = ST_HALT;
                  end
                  TYPE_REG, TYPE_BRANCH: begin
                     pop             = 1'b1;
                     commit_reg_id_d = head_rd;
                     commit_val_d    = head_val;
                     commit_rob_id_d = head_rob_id;
                     if (head_type == TYPE_BRANCH && head_mispredict) begin
                        target_d = head_target;
                        state_d  = ST_PRE_FLUSH;
                     end
                  end
               endcase
            end
         end
         ST_STORE_WAIT: begin
            if (store_ack) begin
               pop         = 1'b1;
               store_req_d = 1'b0;
               state_d     = ST_RUN;
            end
         end
         // link write is visible this cycle; clear follows so it is kept
         ST_PRE_FLUSH: begin
            clear_d    = 1'b1;
            clear_pc_d = target_q;
            cnt_d      = FLUSH_LOAD;
            state_d    = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HALT: begin
            store_req_d = 1'b0;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      retire_count_d = retire_count_q + 32'(pop);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q         <= ST_RUN;
         cnt_q           <= '0;
         target_q        <= '0;
         commit_reg_id_q <= '0;
         commit_val_q    <= '0;
         commit_rob_id_q <= '0;
         store_req_q     <= 1'b0;
         store_rob_id_q  <= '0;
         clear_q         <= 1'b0;
         clear_pc_q      <= '0;
         halted_q        <= 1'b0;
         retire_count_q  <= '0;
      end else if (rdy_in) begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         target_q        <= target_d;
         commit_reg_id_q <= commit_reg_id_d;
         commit_val_q    <= commit_val_d;
         commit_rob_id_q <= commit_rob_id_d;
         store_req_q     <= store_req_d;
         store_rob_id_q  <= store_rob_id_d;
         clear_q         <= clear_d;
         clear_pc_q      <= clear_pc_d;
         halted_q        <= halted_d;
         retire_count_q  <= retire_count_d;
      end
   end

   assign head_pop      = pop && rdy_in;
   assign commit_reg_id = commit_reg_id_q;
   assign commit_val    = commit_val_q;
   assign commit_rob_id = commit_rob_id_q;
   assign store_req     = store_req_q;
   assign store_rob_id  = store_rob_id_q;
   assign clear         = clear_q;
   assign clear_pc      = clear_pc_q;
   assign halted        = halted_q;
   assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed plus random bench for commit_ctrl against a timeline
// model that schedules flush and resume by active-cycle number.
module tb_commit_ctrl;
   import commit_ctrl_pkg::*;

   localparam int FC = 2;

   logic                 clk_in = 1'b0;
   logic                 rst_in = 1'b1;
   logic                 rdy_in = 1'b1;
   logic                 head_valid = 1'b0;
   logic                 head_ready = 1'b0;
   logic [ROB_WIDTH-1:0] head_rob_id = '0;
   logic [1:0]           head_type = TYPE_REG;
   logic [4:0]           head_rd = '0;
   logic [31:0]          head_val = '0;
   logic                 head_mispredict = 1'b0;
   logic [31:0]          head_target = '0;
   logic                 store_ack = 1'b0;
   logic                 head_pop;
   logic [4:0]           commit_reg_id;
   logic [31:0]          commit_val;
   logic [ROB_WIDTH-1:0] commit_rob_id;
   logic                 store_req;
   logic [ROB_WIDTH-1:0] store_rob_id;
   logic                 clear;
   logic [31:0]          clear_pc;
   logic                 halted;
   logic [31:0]          retire_count;

   commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .head_valid      (head_valid),
      .head_ready      (head_ready),
      .head_rob_id     (head_rob_id),
      .head_type       (head_type),
      .head_rd         (head_rd),
      .head_val        (head_val),
      .head_mispredict (head_mispredict),
      .head_target     (head_target),
      .head_pop        (head_pop),
      .commit_reg_id   (commit_reg_id),
      .commit_val      (commit_val),
      .commit_rob_id   (commit_rob_id),
      .store_req       (store_req),
      .store_rob_id    (store_rob_id),
      .store_ack       (store_ack),
      .clear           (clear),
      .clear_pc        (clear_pc),
      .halted          (halted),
      .retire_count    (retire_count)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   // model: time only advances on rdy cycles; flush is a window
   int          acyc;
   int          resume_at;
   int          clear_at;
   bit          in_store;
   bit          halted_m;
   logic [31:0] tgt_m;
   logic [4:0]           e_rd;
   logic [31:0]          e_val;
   logic [ROB_WIDTH-1:0] e_rob;
   logic                 e_sreq;
   logic [ROB_WIDTH-1:0] e_srob;
   logic                 e_clear;
   logic [31:0]          e_cpc;
   logic                 e_halted;
   logic [31:0]          e_count;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      acyc = 0; resume_at = 0; clear_at = -1;
      in_store = 0; halted_m = 0; tgt_m = '0;
      e_rd = '0; e_val = '0; e_rob = '0; e_sreq = 0; e_srob = '0;
      e_clear = 0; e_cpc = '0; e_halted = 0; e_count = '0;
   endtask

   function automatic bit exp_pop();
      if (!rdy_in || halted_m) return 1'b0;
      if (in_store) return store_ack;
      if (acyc < resume_at) return 1'b0;
      return head_valid && head_ready && head_type != TYPE_STORE;
   endfunction

   task automatic model_edge();
      bit p;
      p = exp_pop();
      if (rst_in) begin
         model_reset();
      end else if (rdy_in) begin
         e_rd = '0; e_clear = 0; e_cpc = '0;
         if (p) e_count = e_count + 1;
         if (in_store) begin
            if (store_ack) begin
               in_store = 0; e_sreq = 0;
            end
         end else if (!halted_m && acyc >= resume_at
                      && head_valid && head_ready) begin
            if (head_type == TYPE_STORE) begin
               in_store = 1; e_sreq = 1; e_srob = head_rob_id;
            end else if (head_type == TYPE_HALT) begin
               halted_m = 1;
            end else begin
               e_rd = head_rd; e_val = head_val; e_rob = head_rob_id;
               if (head_type == TYPE_BRANCH && head_mispredict) begin
                  clear_at  = acyc + 2;
                  resume_at = acyc + 2 + FC;
                  tgt_m     = head_target;
               end
            end
         end
         if (acyc + 1 == clear_at) begin
            e_clear = 1; e_cpc = tgt_m;
         end
         e_halted = halted_m;
         acyc++;
      end
   endtask

   task automatic check_outs();
      check("commit_reg_id", 32'(commit_reg_id), 32'(e_rd));
      check("commit_val", commit_val, e_val);
      check("commit_rob_id", 32'(commit_rob_id), 32'(e_rob));
      check("store_req", 32'(store_req), 32'(e_sreq));
      check("store_rob_id", 32'(store_rob_id), 32'(e_srob));
      check("clear", 32'(clear), 32'(e_clear));
      check("clear_pc", clear_pc, e_cpc);
      check("halted", 32'(halted), 32'(e_halted));
      check("retire_count", retire_count, e_count);
      check("clear_vs_commit", 32'(clear && commit_reg_id != 0), 32'd0);
   endtask

   task automatic cycle();
      @(negedge clk_in);
      check("head_pop", 32'(head_pop), 32'(exp_pop()));
      model_edge();
      @(posedge clk_in);
      #1;
      check_outs();
   endtask

   task automatic head(input logic v, input logic [1:0] ty,
                       input logic [4:0] rd, input logic [31:0] val,
                       input logic [ROB_WIDTH-1:0] rob,
                       input logic mis, input logic [31:0] tg);
      head_valid = v; head_ready = v; head_type = ty;
      head_rd = rd; head_val = val; head_rob_id = rob;
      head_mispredict = mis; head_target = tg;
   endtask

   initial begin
      int r;
      model_reset();
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      check_outs();
      rst_in = 1'b0;

      // back-to-back REG commits
      head(1, TYPE_REG, 5'd5, 32'h11, 4'd1, 0, 0); cycle();
      check("t1_rd5", 32'(commit_reg_id), 32'd5);
      head(1, TYPE_REG, 5'd6, 32'h22, 4'd2, 0, 0); cycle();
      head(1, TYPE_REG, 5'd0, 32'h33, 4'd3, 0, 0); cycle();
      head(0, TYPE_REG, 5'd0, 32'h0, 4'd0, 0, 0); cycle();
      check("t1_count", retire_count, 32'd3);

      // store with ack three cycles after req rises
      head(1, TYPE_STORE, 5'd9, 32'h44, 4'd4, 0, 0); cycle();
      check("t2_req", 32'(store_req), 32'd1);
      cycle(); cycle(); cycle();
      store_ack = 1'b1; cycle();
      store_ack = 1'b0;
      head(0, TYPE_REG, 5'd0, 32'h0, 4'd0, 0, 0); cycle();
      check("t2_req_low", 32'(store_req), 32'd0);
      check("t2_count", retire_count, 32'd4);

      // mispredict with link, ready REG heads queued behind
      head(1, TYPE_BRANCH, 5'd1, 32'h104, 4'd5, 1, 32'h200); cycle();
      check("t3_link", commit_val, 32'h104);
      head(1, TYPE_REG, 5'd7, 32'h55, 4'd6, 0, 0); cycle();
      check("t3_clear", 32'(clear), 32'd1);
      check("t3_pc", clear_pc, 32'h200);
      cycle(); cycle(); cycle();
      check("t3_resume", 32'(commit_reg_id), 32'd7);

      // stall during flush
      head(1, TYPE_BRANCH, 5'd2, 32'h208, 4'd7, 1, 32'h300); cycle();
      head(1, TYPE_REG, 5'd8, 32'h66, 4'd8, 0, 0); cycle(); cycle();
      rdy_in = 1'b0; cycle(); cycle();
      rdy_in = 1'b1; cycle(); cycle(); cycle();

      // reset while waiting for a store ack
      head(1, TYPE_STORE, 5'd3, 32'h77, 4'd9, 0, 0); cycle(); cycle();
      rst_in = 1'b1; head(0, TYPE_REG, 5'd0, 32'h0, 4'd0, 0, 0); cycle();
      check("t6_req", 32'(store_req), 32'd0);
      check("t6_count", retire_count, 32'd0);
      rst_in = 1'b0; cycle();

      // halt absorbs further ready heads
      head(1, TYPE_HALT, 5'd0, 32'h0, 4'd10, 0, 0); cycle();
      head(1, TYPE_REG, 5'd4, 32'h88, 4'd11, 0, 0); cycle(); cycle(); cycle();
      check("t4_halted", 32'(halted), 32'd1);
      check("t4_count", retire_count, 32'd1);
      rst_in = 1'b1; cycle(); rst_in = 1'b0;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_in = ($urandom_range(0, 99) == 0);
         rdy_in = ($urandom_range(0, 7) != 0);
         store_ack = ($urandom_range(0, 2) == 0);
         r = int'($urandom_range(0, 31));
         head_valid = rst_in ? 1'b0 : ($urandom_range(0, 4) != 0);
         head_ready = ($urandom_range(0, 3) != 0);
         head_type = (r == 0) ? TYPE_HALT : (r < 6) ? TYPE_STORE :
                     (r < 14) ? TYPE_BRANCH : TYPE_REG;
         head_rd = 5'($urandom);
         head_val = $urandom;
         head_rob_id = ROB_WIDTH'($urandom);
         head_mispredict = ($urandom_range(0, 3) == 0);
         head_target = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
